// File: rtl/cv32e40s_pkg.sv
// Shared OBI integrity helpers: per-byte odd-parity check bits and the responder's
// outstanding-transaction record.
package cv32e40s_pkg;

  typedef struct packed {
    logic fault;
    logic we;
  } obi_resp_entry_t;

  // Odd parity per address byte: check bit is set when the byte holds an even number of ones.
  function automatic logic [3:0] achk_calc(input logic [31:0] addr);
    logic [3:0] chk;
    for (int i = 0; i < 4; i++) begin
      chk[i] = ~^addr[8*i +: 8];
    end
    return chk;
  endfunction

  function automatic logic [4:0] rchk_calc(input logic [31:0] rdata, input logic err,
                                           input logic exokay);
    logic [4:0] chk;
    for (int i = 0; i < 4; i++) begin
      chk[i] = ~^rdata[8*i +: 8];
    end
    chk[4] = ~^{err, exokay};
    return chk;
  endfunction

endpackage

// File: rtl/cv32e40s_rchk_gen.sv
// Response check-bit generator (rdata, err, exokay -> rchk); purely combinational,
// mirror image of the requester-side rchk checker.
module cv32e40s_rchk_gen
  import cv32e40s_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic        err,
  input  logic        exokay,
  output logic [4:0]  rchk
);

  assign rchk = rchk_calc(rdata, err, exokay);

endmodule

// File: rtl/cv32e40s_obi_integrity_responder.sv
// OBI responder with request integrity checking; grant is combinational, response is
// registered one cycle after the backend answers; no grant once MAX_OUTSTANDING are pending.
module cv32e40s_obi_integrity_responder
  import cv32e40s_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        obi_req_i,
  input  logic        obi_reqpar_i,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  input  logic [3:0]  obi_achk_i,
  output logic        obi_gnt_o,
  output logic        obi_gntpar_o,
  output logic        obi_rvalid_o,
  output logic        obi_rvalidpar_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic        obi_exokay_o,
  output logic [4:0]  obi_rchk_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(MAX_OUTSTANDING - 1);

  obi_resp_entry_t fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic        rvalid_q, err_q, protocol_err_q;
  logic [31:0] rdata_q;

  logic            fault, push, pop;
  obi_resp_entry_t push_entry, head;

  // Grant only looks at the current count, so a same-cycle pop never frees a slot.
  assign obi_gnt_o    = obi_req_i && (cnt_q != CNT_MAX);
  assign obi_gntpar_o = ~obi_gnt_o;

  assign fault = obi_req_i && ((obi_reqpar_i != ~obi_req_i) ||
                               (obi_achk_i != achk_calc(obi_addr_i)));
  assign push  = obi_req_i && obi_gnt_o;
  assign pop   = mem_rvalid_i && (cnt_q != '0);

  assign push_entry = '{fault: fault, we: obi_we_i};
  assign head       = fifo_q[rd_ptr_q];

  assign mem_req_o   = push;
  assign mem_we_o    = obi_we_i && !fault;
  assign mem_addr_o  = obi_addr_i;
  assign mem_be_o    = obi_be_i;
  assign mem_wdata_o = obi_wdata_i;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Writes and faulted requests never return backend data; rdata/err hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      rvalid_q <= pop;
      if (pop) begin
        rdata_q <= (head.we || head.fault) ? 32'h0 : mem_rdata_i;
        err_q   <= mem_err_i || head.fault;
      end
      if (mem_rvalid_i && (cnt_q == '0)) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

  assign obi_rvalid_o    = rvalid_q;
  assign obi_rvalidpar_o = ~rvalid_q;
  assign obi_rdata_o     = rdata_q;
  assign obi_err_o       = err_q;
  assign obi_exokay_o    = 1'b0;
  assign protocol_err_o  = protocol_err_q;

  cv32e40s_rchk_gen u_rchk_gen (
    .rdata  (rdata_q),
    .err    (err_q),
    .exokay (1'b0),
    .rchk   (obi_rchk_o)
  );

endmodule

// File: tb/tb_cv32e40s_obi_integrity_responder.sv
// Bench for the OBI integrity responder: directed vector table, corner sequences and
// random traffic, all checked against a queue-based transaction model.
module tb_cv32e40s_obi_integrity_responder;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        obi_req, obi_reqpar, obi_we;
  logic [31:0] obi_addr, obi_wdata;
  logic [3:0]  obi_be, obi_achk;
  logic        obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_err, obi_exokay;
  logic [31:0] obi_rdata;
  logic [4:0]  obi_rchk;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        protocol_err;

  always #5 clk = ~clk;

  cv32e40s_obi_integrity_responder #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .obi_req_i(obi_req), .obi_reqpar_i(obi_reqpar), .obi_addr_i(obi_addr),
    .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata), .obi_achk_i(obi_achk),
    .obi_gnt_o(obi_gnt), .obi_gntpar_o(obi_gntpar), .obi_rvalid_o(obi_rvalid),
    .obi_rvalidpar_o(obi_rvalidpar), .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .obi_exokay_o(obi_exokay), .obi_rchk_o(obi_rchk),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err), .protocol_err_o(protocol_err)
  );

  typedef struct {
    bit        req, badpar, badachk, we;
    bit [31:0] addr;
    bit        mrv;
    bit [31:0] mrdata;
    bit        merr;
    bit        has_exp;
    bit        e_gnt, e_mwe, e_rvalid;
    bit [31:0] e_rdata;
    bit        e_err;
  } vec_t;

  typedef struct { bit fault; bit we; } txn_t;

  int checks = 0;
  int errors = 0;

  txn_t      mq[$];
  bit        m_rvalid, m_err, m_perr;
  bit [31:0] m_rdata;

  function automatic vec_t nv(bit req, bit badpar, bit badachk, bit we, bit [31:0] addr,
                              bit mrv, bit [31:0] mrdata, bit merr);
    vec_t v;
    v = '{req: req, badpar: badpar, badachk: badachk, we: we, addr: addr, mrv: mrv,
          mrdata: mrdata, merr: merr, has_exp: 1'b0, e_gnt: 1'b0, e_mwe: 1'b0,
          e_rvalid: 1'b0, e_rdata: 32'h0, e_err: 1'b0};
    return v;
  endfunction

  function automatic vec_t tv(bit req, bit badpar, bit badachk, bit we, bit [31:0] addr,
                              bit mrv, bit [31:0] mrdata, bit merr,
                              bit e_gnt, bit e_mwe, bit e_rvalid, bit [31:0] e_rdata, bit e_err);
    vec_t v;
    v = nv(req, badpar, badachk, we, addr, mrv, mrdata, merr);
    v.has_exp = 1'b1; v.e_gnt = e_gnt; v.e_mwe = e_mwe;
    v.e_rvalid = e_rvalid; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  // Check bit = 1 when the byte has an even number of ones (total parity odd).
  function automatic bit [3:0] byte_chk(bit [31:0] w);
    bit [3:0] c;
    for (int i = 0; i < 4; i++) c[i] = ($countones(w[8*i +: 8]) % 2) == 0;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rvalid = 0; m_rdata = 0; m_err = 0; m_perr = 0;
  endtask

  task automatic step(input vec_t v);
    bit   exp_push, fault;
    txn_t t;
    obi_req    = v.req;
    obi_reqpar = v.badpar ? v.req : ~v.req;
    obi_addr   = v.addr;
    obi_we     = v.we;
    obi_be     = 4'($urandom);
    obi_wdata  = $urandom;
    obi_achk   = byte_chk(v.addr) ^ {3'b000, v.badachk};
    mem_rvalid = v.mrv;
    mem_rdata  = v.mrdata;
    mem_err    = v.merr;
    @(negedge clk);
    exp_push = v.req && (mq.size() < MAXO);
    fault    = v.req && (v.badpar || v.badachk);
    chk("gnt", obi_gnt, exp_push);
    chk("gntpar", obi_gntpar, !exp_push);
    chk("mem_req", mem_req, exp_push);
    if (exp_push) begin
      chk("mem_we", mem_we, v.we && !fault);
      chk("mem_addr", mem_addr, v.addr);
      chk("mem_wdata", mem_wdata, obi_wdata);
      chk("mem_be", mem_be, obi_be);
    end
    chk("rvalid", obi_rvalid, m_rvalid);
    chk("rvalidpar", obi_rvalidpar, !m_rvalid);
    chk("rdata", obi_rdata, m_rdata);
    chk("err", obi_err, m_err);
    chk("rchk", obi_rchk, {!m_err, byte_chk(m_rdata)});
    chk("exokay", obi_exokay, 1'b0);
    chk("protocol_err", protocol_err, m_perr);
    if (v.has_exp) begin
      chk("tbl_gnt", obi_gnt, v.e_gnt);
      if (v.e_gnt) chk("tbl_mem_we", mem_we, v.e_mwe);
      chk("tbl_rvalid", obi_rvalid, v.e_rvalid);
      chk("tbl_rdata", obi_rdata, v.e_rdata);
      chk("tbl_err", obi_err, v.e_err);
      chk("tbl_protocol_err", protocol_err, 1'b0);
    end
    @(posedge clk);
    m_rvalid = 0;
    if (v.mrv && mq.size() == 0) m_perr = 1;
    else if (v.mrv) begin
      t = mq.pop_front();
      m_rvalid = 1;
      m_rdata  = (t.we || t.fault) ? 32'h0 : v.mrdata;
      m_err    = v.merr || t.fault;
    end
    if (exp_push) mq.push_back('{fault: fault, we: v.we});
    #1;
  endtask

  task automatic do_reset();
    rst = 1; obi_req = 0; mem_rvalid = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      tv(0,0,0,0,32'h0,   0,32'h0,0,         0,0,0,32'h0,0),
      tv(1,0,0,0,32'h100, 0,32'h0,0,         1,0,0,32'h0,0),
      tv(0,0,0,0,32'h0,   1,32'hA5A5_0F0F,0, 0,0,0,32'h0,0),
      tv(0,0,0,0,32'h0,   0,32'h0,0,         0,0,1,32'hA5A5_0F0F,0),
      tv(1,1,0,1,32'h200, 0,32'h0,0,         1,0,0,32'hA5A5_0F0F,0),
      tv(0,0,0,0,32'h0,   1,32'h1234_5678,0, 0,0,0,32'hA5A5_0F0F,0),
      tv(0,0,0,0,32'h0,   0,32'h0,0,         0,0,1,32'h0,1),
      tv(1,0,1,0,32'h300, 0,32'h0,0,         1,0,0,32'h0,1),
      tv(0,0,0,0,32'h0,   1,32'hDEAD_BEEF,0, 0,0,0,32'h0,1),
      tv(0,0,0,0,32'h0,   0,32'h0,0,         0,0,1,32'h0,1),
      tv(1,0,0,1,32'h400, 0,32'h0,0,         1,1,0,32'h0,1),
      tv(0,0,0,0,32'h0,   1,32'h0000_FFFF,1, 0,0,0,32'h0,1),
      tv(0,0,0,0,32'h0,   0,32'h0,0,         0,0,1,32'h0,1),
      tv(1,0,0,0,32'h500, 0,32'h0,0,         1,0,0,32'h0,1),
      tv(0,0,0,0,32'h0,   1,32'h0000_00F0,1, 0,0,0,32'h0,1),
      tv(0,0,0,0,32'h0,   0,32'h0,0,         0,0,1,32'h0000_00F0,1)
    };

    rst = 1; obi_req = 0; obi_reqpar = 1; obi_addr = 0; obi_we = 0; obi_be = 0;
    obi_wdata = 0; obi_achk = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();

    foreach (tbl[i]) step(tbl[i]);

    // Backpressure at MAX_OUTSTANDING; a pop does not re-open grant in the same cycle.
    step(nv(1,0,0,0,32'h10, 0,0,0));
    step(nv(1,0,0,0,32'h14, 0,0,0));
    step(nv(1,0,0,0,32'h18, 0,0,0));
    step(nv(1,0,0,0,32'h18, 1,32'h11,0));
    step(nv(1,0,0,0,32'h1C, 0,0,0));
    step(nv(0,0,0,0,32'h0,  1,32'h22,0));
    step(nv(0,0,0,0,32'h0,  1,32'h33,0));
    step(nv(0,0,0,0,32'h0,  0,0,0));

    // Simultaneous push and pop with one outstanding.
    step(nv(1,0,0,0,32'h40, 0,0,0));
    step(nv(1,0,1,0,32'h44, 1,32'h55,0));
    step(nv(0,0,0,0,32'h0,  1,32'h66,0));
    step(nv(0,0,0,0,32'h0,  0,0,0));

    for (int n = 0; n < 400; n++) begin
      bit mrv;
      mrv = (mq.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      step(nv($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 1), $urandom, mrv, $urandom, $urandom_range(0, 5) == 0));
    end
    while (mq.size() != 0) step(nv(0,0,0,0,32'h0, 1,$urandom,0));
    step(nv(0,0,0,0,32'h0, 0,0,0));

    // Reset with two outstanding drops them; a late backend response is then a protocol error.
    do_reset();
    step(nv(1,0,0,0,32'h80, 0,0,0));
    step(nv(1,0,0,0,32'h84, 0,0,0));
    do_reset();
    step(nv(0,0,0,0,32'h0, 1,32'h77,0));
    step(nv(0,0,0,0,32'h0, 0,0,0));
    step(nv(1,0,0,0,32'h88, 0,0,0));
    step(nv(0,0,0,0,32'h0, 1,32'h99,0));
    step(nv(0,0,0,0,32'h0, 0,0,0));
    do_reset();
    step(nv(0,0,0,0,32'h0, 0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
